// File: rtl/dmem_responder.sv
// Single-request data-memory responder for an RV32I load/store port.
// Each request is held for WAIT_STATES cycles, then answered with extended load data or an error flag.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 32'd0) ? 4'd0 : 4'(WAIT_STATES - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept_s, enter_resp_s, mem_we_s;
    logic        cur_we_s;
    logic [2:0]  cur_f3_s;
    logic [31:0] cur_addr_s, cur_wdata_s;
    logic        err_s;
    logic [AW-1:0] widx_s;
    logic [31:0] rd_word_s, rd_shift_s, load_s, st_data_s;
    logic [3:0]  be_s;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign accept_s     = req_valid && (state_q == S_IDLE);
    assign enter_resp_s = (state_d == S_RESP) && (state_q != S_RESP);
    assign mem_we_s     = enter_resp_s && cur_we_s && !err_s && reset;

    // State and wait counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (WAIT_STATES == 32'd0)) begin
                    state_d = S_RESP;
                end else if (accept_s) begin
                    state_d = S_WAIT;
                    cnt_d   = WS_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_WAIT:  req_ready = 1'b0;
            S_RESP:  rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Request capture on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept_s) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end else begin
            we_q    <= we_q;
            f3_q    <= f3_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
        end
    end

    // With zero wait states the response is formed on the accept edge, so use live inputs in IDLE
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we_s    = req_we;
            cur_f3_s    = req_funct3;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = we_q;
            cur_f3_s    = f3_q;
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
        end
    end

    // Error classification: illegal code, misalignment, out of range
    always_comb begin
        err_s = 1'b0;
        case (cur_f3_s)
            3'b000:  err_s = 1'b0;
            3'b001:  err_s = cur_addr_s[0];
            3'b010:  err_s = (cur_addr_s[1:0] != 2'b00);
            3'b100:  err_s = cur_we_s;
            3'b101:  err_s = cur_we_s || cur_addr_s[0];
            default: err_s = 1'b1;
        endcase
        if (|cur_addr_s[31:AW+2]) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    assign widx_s     = cur_addr_s[AW+1:2];
    assign rd_word_s  = mem_q[widx_s];
    assign rd_shift_s = rd_word_s >> {cur_addr_s[1:0], 3'b000};

    // Load extraction and store lane steering
    always_comb begin
        load_s    = 32'd0;
        be_s      = 4'b0000;
        st_data_s = cur_wdata_s;
        case (cur_f3_s)
            3'b000: begin
                load_s    = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
                be_s      = 4'b0001 << cur_addr_s[1:0];
                st_data_s = {4{cur_wdata_s[7:0]}};
            end
            3'b001: begin
                load_s    = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
                be_s      = cur_addr_s[1] ? 4'b1100 : 4'b0011;
                st_data_s = {2{cur_wdata_s[15:0]}};
            end
            3'b010: begin
                load_s = rd_word_s;
                be_s   = 4'b1111;
            end
            3'b100:  load_s = {24'd0, rd_shift_s[7:0]};
            3'b101:  load_s = {16'd0, rd_shift_s[15:0]};
            default: load_s = 32'd0;
        endcase
        if (err_s || cur_we_s) begin
            rdata_d = 32'd0;
        end else begin
            rdata_d = load_s;
        end
        err_d = err_s;
    end

    // Response registers, loaded on the edge entering RESP and held until the next request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp_s) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end else begin
            rdata_q <= rdata_q;
            err_q   <= err_q;
        end
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= st_data_s[8*i +: 8];
                end
            end
        end
    end

endmodule
